// File: rtl/contador16_ud_monitor_pkg.sv
// Shared types and constants for the up/down bouncing counter and its monitor.
// Direction encoding is common to both the generator and the checker.
package contador_pkg;

    typedef enum logic [1:0] {IDLE, ACQ, UP, DOWN} mon_state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/contador16_ud_monitor_if.sv
// Sample stream in, monitor status out; master drives samples, slave is the monitor.
// All signals sampled/driven on the monitor clock.
interface contador16_ud_monitor_if #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 16,
    parameter int ECNT_W = 8
);
    logic              sync;
    logic              in_valid;
    logic [WIDTH-1:0]  din;
    logic              locked;
    logic              dir;
    logic [WIDTH-1:0]  exp_val;
    logic              peak;
    logic              trough;
    logic              err;
    logic [PCNT_W-1:0] period_cnt;
    logic [ECNT_W-1:0] err_cnt;

    modport master (
        output sync, in_valid, din,
        input  locked, dir, exp_val, peak, trough, err, period_cnt, err_cnt
    );

    modport slave (
        input  sync, in_valid, din,
        output locked, dir, exp_val, peak, trough, err, period_cnt, err_cnt
    );
endinterface

// File: rtl/contador16_ud_monitor_ud_step_predict.sv
// Next expected value and direction after accepting ref_val while moving in dir_in.
// Purely combinational; turns around at MAX (going up) and at 0 (going down).
module ud_step_predict
    import contador_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] ref_val,
    input  logic             dir_in,
    output logic [WIDTH-1:0] nxt_val,
    output logic             nxt_dir
);
    localparam logic [WIDTH-1:0] MAX = '1;

    always_comb begin
        nxt_dir = dir_in;
        nxt_val = ref_val;
        if (dir_in == DIR_UP) begin
            if (ref_val == MAX) begin
                nxt_dir = DIR_DOWN;
                nxt_val = MAX - WIDTH'(1);
            end else begin
                nxt_val = ref_val + WIDTH'(1);
            end
        end else begin
            if (ref_val == '0) begin
                nxt_dir = DIR_UP;
                nxt_val = WIDTH'(1);
            end else begin
                nxt_val = ref_val - WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/contador16_ud_monitor.sv
// Checks a bouncing up/down counter stream: locks on direction, predicts, flags errors.
// One-cycle latency: a sample accepted on edge N shows in outputs from edge N.
module contador16_ud_monitor
    import contador_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 16,
    parameter int ECNT_W = 8
) (
    input  logic                    clk,
    input  logic                    clr_n,
    contador16_ud_monitor_if.slave  mon
);
    localparam logic [WIDTH-1:0] MAX = '1;

    mon_state_t        state;
    logic [WIDTH-1:0]  ref_q;
    logic              locked_q;
    logic              dir_q;
    logic [WIDTH-1:0]  exp_q;
    logic              peak_q;
    logic              trough_q;
    logic              err_q;
    logic [PCNT_W-1:0] pcnt_q;
    logic [ECNT_W-1:0] ecnt_q;

    logic             up_step;
    logic             dn_step;
    logic             step_dir;
    logic             is_locked_state;
    logic             take;
    logic             accept;
    logic             mismatch;
    logic [WIDTH-1:0] nxt_val;
    logic             nxt_dir;

    // Acquisition only counts non-wrapping single steps as evidence of a direction.
    assign up_step  = (ref_q != MAX) && (mon.din == ref_q + WIDTH'(1));
    assign dn_step  = (ref_q != '0)  && (mon.din == ref_q - WIDTH'(1));
    assign step_dir = (state == ACQ) ? (up_step ? DIR_UP : DIR_DOWN) : dir_q;

    assign is_locked_state = (state == UP) || (state == DOWN);
    assign take     = mon.in_valid && !mon.sync;
    assign accept   = take && (((state == ACQ) && (up_step || dn_step)) ||
                               (is_locked_state && (mon.din == exp_q)));
    assign mismatch = take && is_locked_state && (mon.din != exp_q);

    ud_step_predict #(.WIDTH(WIDTH)) u_pred (
        .ref_val (mon.din),
        .dir_in  (step_dir),
        .nxt_val (nxt_val),
        .nxt_dir (nxt_dir)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= IDLE;
            ref_q    <= '0;
            locked_q <= 1'b0;
            dir_q    <= DIR_UP;
            exp_q    <= '0;
            peak_q   <= 1'b0;
            trough_q <= 1'b0;
            err_q    <= 1'b0;
            pcnt_q   <= '0;
            ecnt_q   <= '0;
        end else begin
            peak_q   <= 1'b0;
            trough_q <= 1'b0;
            err_q    <= 1'b0;
            if (mon.sync) begin
                state    <= IDLE;
                locked_q <= 1'b0;
                dir_q    <= DIR_UP;
            end else if (accept) begin
                ref_q    <= mon.din;
                locked_q <= 1'b1;
                exp_q    <= nxt_val;
                dir_q    <= nxt_dir;
                state    <= (nxt_dir == DIR_UP) ? UP : DOWN;
                peak_q   <= (step_dir == DIR_UP) && (mon.din == MAX);
                if ((step_dir == DIR_DOWN) && (mon.din == '0)) begin
                    trough_q <= 1'b1;
                    pcnt_q   <= pcnt_q + PCNT_W'(1);
                end
            end else if (mismatch) begin
                err_q    <= 1'b1;
                locked_q <= 1'b0;
                ref_q    <= mon.din;
                state    <= ACQ;
                if (ecnt_q != '1) ecnt_q <= ecnt_q + ECNT_W'(1);
            end else if (take) begin
                // IDLE takes its first reference; ACQ re-bases on a non-step sample.
                ref_q <= mon.din;
                state <= ACQ;
            end
        end
    end

    assign mon.locked     = locked_q;
    assign mon.dir        = dir_q;
    assign mon.exp_val    = exp_q;
    assign mon.peak       = peak_q;
    assign mon.trough     = trough_q;
    assign mon.err        = err_q;
    assign mon.period_cnt = pcnt_q;
    assign mon.err_cnt    = ecnt_q;
endmodule

// File: tb/tb_contador16_ud_monitor.sv
// Randomized and directed check of contador16_ud_monitor against an integer reference model.
module tb_contador16_ud_monitor;
    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    contador16_ud_monitor_if #(.WIDTH(4), .PCNT_W(16), .ECNT_W(8)) mon ();

    contador16_ud_monitor #(.WIDTH(4), .PCNT_W(16), .ECNT_W(8)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .mon   (mon)
    );

    always #5 clk = ~clk;

    // Reference model: last reference sample (-1 = none), lock flag, prediction.
    bit m_locked, m_dir, m_peak, m_trough, m_err;
    int m_ref, m_exp, m_pcnt, m_ecnt;

    function automatic void model_reset();
        m_locked = 0; m_dir = 0; m_peak = 0; m_trough = 0; m_err = 0;
        m_ref = -1; m_exp = 0; m_pcnt = 0; m_ecnt = 0;
    endfunction

    function automatic void model_accept(int d, bit up_dir);
        m_locked = 1;
        m_ref    = d;
        if (!up_dir && d == 15) begin
            m_peak = 1; m_dir = 1; m_exp = 14;
        end else if (up_dir && d == 0) begin
            m_trough = 1; m_pcnt = (m_pcnt + 1) % 65536; m_dir = 0; m_exp = 1;
        end else begin
            m_dir = up_dir;
            m_exp = up_dir ? d - 1 : d + 1;
        end
    endfunction

    function automatic void model_step(bit v, int d, bit s);
        m_peak = 0; m_trough = 0; m_err = 0;
        if (s) begin
            m_ref = -1; m_locked = 0; m_dir = 0;
        end else if (v) begin
            if (m_locked) begin
                if (d == m_exp) model_accept(d, m_dir);
                else begin
                    m_err = 1;
                    if (m_ecnt < 255) m_ecnt++;
                    m_locked = 0;
                    m_ref = d;
                end
            end else if (m_ref < 0)       m_ref = d;
            else if (d == m_ref + 1)      model_accept(d, 0);
            else if (d == m_ref - 1)      model_accept(d, 1);
            else                          m_ref = d;
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("locked",     int'(mon.locked),     int'(m_locked));
        chk("dir",        int'(mon.dir),        int'(m_dir));
        chk("peak",       int'(mon.peak),       int'(m_peak));
        chk("trough",     int'(mon.trough),     int'(m_trough));
        chk("err",        int'(mon.err),        int'(m_err));
        chk("period_cnt", int'(mon.period_cnt), m_pcnt);
        chk("err_cnt",    int'(mon.err_cnt),    m_ecnt);
        if (m_locked) chk("exp_val", int'(mon.exp_val), m_exp);
    endtask

    task automatic step(input bit v, input int d, input bit s);
        @(negedge clk);
        mon.in_valid = v;
        mon.din      = 4'(d);
        mon.sync     = s;
        model_step(v, d, s);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n = 1'b0;
        mon.in_valid = 1'b0;
        mon.sync = 1'b0;
        model_reset();
        #1;
        compare();
        chk("rst_exp_val", int'(mon.exp_val), 0);
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic run_random(input int n);
        int g = $urandom_range(0, 15);
        bit gd = 0;
        for (int i = 0; i < n; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 3)       step(1, $urandom_range(0, 15), 1);
            else if (r < 15) step(0, $urandom_range(0, 15), 0);
            else if (r < 22) step(1, $urandom_range(0, 15), 0);
            else begin
                step(1, g, 0);
                if (!gd && g == 15) gd = 1;
                else if (gd && g == 0) gd = 0;
                g = gd ? g - 1 : g + 1;
            end
        end
    endtask

    initial begin
        mon.in_valid = 1'b0;
        mon.din      = '0;
        mon.sync     = 1'b0;
        model_reset();

        // Reset state, then 0,1,2.
        do_reset();
        chk("rst_locked", int'(mon.locked), 0);
        step(1, 0, 0);
        chk("one_sample_unlocked", int'(mon.locked), 0);
        step(1, 1, 0);
        step(1, 2, 0);
        chk("lock_locked", int'(mon.locked), 1);
        chk("lock_exp_val", int'(mon.exp_val), 3);
        chk("lock_dir", int'(mon.dir), 0);

        // Full triangle up to 15, down to 0, up to 15.
        for (int v = 3; v <= 15; v++) step(1, v, 0);
        chk("tri_peak", int'(mon.peak), 1);
        chk("tri_dir_down", int'(mon.dir), 1);
        for (int v = 14; v >= 0; v--) step(1, v, 0);
        chk("tri_trough", int'(mon.trough), 1);
        chk("tri_period", int'(mon.period_cnt), 1);
        chk("tri_dir_up", int'(mon.dir), 0);
        for (int v = 1; v <= 15; v++) step(1, v, 0);
        chk("tri_peak2", int'(mon.peak), 1);

        // Injected error and relock.
        do_reset();
        step(1, 5, 0); step(1, 6, 0); step(1, 7, 0);
        step(1, 9, 0);
        chk("inj_err", int'(mon.err), 1);
        chk("inj_err_cnt", int'(mon.err_cnt), 1);
        chk("inj_unlocked", int'(mon.locked), 0);
        step(1, 10, 0); step(1, 11, 0);
        chk("relock_exp", int'(mon.exp_val), 12);

        // Acquisition on the down slope / onto a trough.
        do_reset();
        step(1, 15, 0); step(1, 14, 0);
        chk("acq_down_locked", int'(mon.locked), 1);
        chk("acq_down_nopeak", int'(mon.peak), 0);
        do_reset();
        step(1, 1, 0); step(1, 0, 0);
        chk("acq_trough", int'(mon.trough), 1);
        chk("acq_trough_period", int'(mon.period_cnt), 1);

        // Gap, illegal wrap, saturation.
        do_reset();
        step(1, 2, 0); step(1, 3, 0);
        for (int i = 0; i < 4; i++) step(0, 7, 0);
        step(1, 4, 0);
        chk("gap_locked", int'(mon.locked), 1);
        chk("gap_no_err", int'(mon.err_cnt), 0);
        step(1, 14, 0); step(1, 15, 0); step(1, 0, 0);
        chk("wrap_err", int'(mon.err), 1);
        do_reset();
        step(1, 3, 0); step(1, 4, 0); step(1, 3, 0);
        for (int i = 0; i < 259; i++) begin step(1, 4, 0); step(1, 3, 0); end
        chk("err_saturate", int'(mon.err_cnt), 255);

        // Sync with valid, then relock keeping counters.
        do_reset();
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
        step(1, 2, 1);
        chk("sync_unlocked", int'(mon.locked), 0);
        chk("sync_period_held", int'(mon.period_cnt), 1);
        step(1, 7, 0); step(1, 8, 0);
        chk("sync_relock", int'(mon.locked), 1);

        // Random traffic.
        do_reset();
        run_random(3000);

        // Asynchronous clear between edges.
        @(negedge clk);
        #2;
        clr_n = 1'b0;
        model_reset();
        #1;
        compare();
        chk("async_period", int'(mon.period_cnt), 0);
        chk("async_exp_val", int'(mon.exp_val), 0);
        @(negedge clk);
        clr_n = 1'b1;
        step(1, 6, 0); step(1, 7, 0);
        chk("post_clr_lock", int'(mon.locked), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/contador16_ud_monitor.md
Name: contador16_ud_monitor

Overview:
- Receive-side checker for the bouncing up/down counter stream (0,1,…,15,14,…,0,1,…).
- Samples the counter value each qualified cycle, locks onto the direction, predicts the next value and flags deviations.
- Reports turnarounds (peak/trough), completed periods and error counts.
- Sits downstream of the counter in the lab top level and drives LEDs and the self-check harness.

Parameters:
- WIDTH, 4, bit width of the monitored counter value; MAX = 2**WIDTH-1.
- PCNT_W, 16, width of the period counter.
- ECNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single clock; all logic on posedge.
- clr_n  in  1  reset, asynchronous, active-low; clears all state and outputs.
- sync  in  1  synchronous resync: return to IDLE, keep counters.
- in_valid  in  1  din is a valid sample this cycle.
- din  in  WIDTH  counter value under observation.
- locked  out  1  monitor is tracking a consistent sequence.
- dir  out  1  expected direction of the next step: 0 = up, 1 = down.
- exp_val  out  WIDTH  predicted next sample; meaningful only while locked.
- peak  out  1  one-cycle pulse: MAX accepted while locked up.
- trough  out  1  one-cycle pulse: 0 accepted while locked down.
- err  out  1  one-cycle pulse: mismatch while locked.
- period_cnt  out  PCNT_W  number of troughs seen; wraps at 2**PCNT_W.
- err_cnt  out  ECNT_W  number of errors; saturates at all-ones.

Behaviour:
- Reset (clr_n=0, async): state=IDLE, locked=0, dir=0, exp_val=0, peak=trough=err=0, period_cnt=0, err_cnt=0, ref register=0.
- Outputs are registered and reflect a sample accepted on edge N from edge N (visible in cycle N+1). Pulses last exactly one cycle.
- in_valid=0 holds all state; pulses deassert.
- States:
  - IDLE: valid sample → store ref=din, go to ACQ.
  - ACQ: valid sample d; classify against ref:
    - d=ref+1 (no wrap) or (ref=0, d=1) → UP.
    - d=ref-1 (no wrap) or (ref=MAX, d=MAX-1) → DOWN.
    - Otherwise → stay ACQ with ref=d, no err pulse.
    - On entering UP/DOWN, locked=1 and the turnaround rules below are applied to d.
  - UP: expected = ref+1.
    - d equal → accept. If d=MAX: peak=1, next expected MAX-1, go DOWN (dir=1).
  - DOWN: expected = ref-1.
    - d equal → accept. If d=0: trough=1, period_cnt+1, next expected 1, go UP (dir=0).
  - Mismatch in UP/DOWN: err=1, err_cnt+1 (saturating), locked=0, ref=d, go ACQ.
- Acquisition landing on a turnaround:
  - ACQ 14→15 locks UP and pulses peak in the same cycle.
  - ACQ 1→0 locks DOWN and pulses trough, incrementing period_cnt.
- Arithmetic is modulo 2**WIDTH only for the prediction. Wrap sequences (MAX→0, 0→MAX) are never legal steps: they count as errors when locked and do not lock in ACQ.
- Repeated value (d=ref) is a mismatch when locked and does not lock in ACQ.
- sync=1 takes priority over in_valid: state=IDLE, locked=0, dir=0, pulses=0. period_cnt and err_cnt are kept.
- clr_n deasserted mid-sequence restarts from IDLE. Two valid samples are needed before locked=1.
- exp_val is updated on every accepted sample while locked; it holds its last value otherwise.

Decomposition:
- Package contador_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACQ, UP, DOWN} mon_state_t;
  - constants DIR_UP=1'b0 and DIR_DOWN=1'b1, shared with the counter block.
- One sub-module is natural: ud_step_predict (combinational). Inputs ref and dir; outputs next expected value and next dir, applying the MAX/0 turnaround rule. Both ACQ classification and the locked check use it.
- Everything else stays in the single FSM/counter module.

Test Plan:
- Reset, then valid stream 0,1,2 → locked=1 after the 2nd sample, dir=0, exp_val=3; no err.
- Full triangle 0..15..0..15 → peak pulses at each 15, trough at each 0 after the first down slope; period_cnt=1 after first 15→0; dir toggles to 1 after 15 and to 0 after 0.
- Locked on 5,6,7, then inject 9 → err pulse in that cycle, err_cnt=1, locked=0. Then 10,11 → relock UP, exp_val=12.
- Starting stream 15,14 → locks DOWN with no peak. 1,0 from ACQ → locks DOWN, trough=1, period_cnt increments.
- Gap handling: 3,(in_valid=0 ×4),4 → still locked, no err. Illegal wrap 15→0 while UP → err. 260 consecutive errors → err_cnt stays at 255.
- Mid-stream: sync=1 with in_valid=1 → IDLE, locked=0, counters held. Async clr_n pulse between edges → all outputs 0 immediately.
